// File: rtl/cellram_pkg.sv
// Shared definitions for the CellularRAM burst responder: state encoding,
// bus widths and the default read latency.
package cellram_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWriteBurst,
        StReadWait,
        StReadBurst
    } state_e;

    localparam int unsigned DefaultReadLatency = 3;
    localparam int unsigned AddrWidth          = 23;
    localparam int unsigned DataWidth          = 16;

endpackage

// File: rtl/cellram_array.sv
// Single-port word storage: synchronous write, registered read (read-first).
module cellram_array
    import cellram_pkg::*;
#(
    parameter int unsigned MEM_DEPTH_LOG2 = 16
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [MEM_DEPTH_LOG2-1:0] addr,
    input  logic [DataWidth-1:0]      wdata,
    output logic [DataWidth-1:0]      rdata
);

    logic [DataWidth-1:0] mem [2**MEM_DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/cellram_responder.sv
// Synchronous-burst CellularRAM device model: address-strobed write and read
// bursts with a fixed read latency, word counters and sticky error flags.
module cellram_responder
    import cellram_pkg::*;
#(
    parameter int unsigned MEM_DEPTH_LOG2 = 16,
    parameter int unsigned READ_LATENCY   = DefaultReadLatency
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [AddrWidth-1:0] mem_addr,
    inout  wire  [DataWidth-1:0] mem_data,
    input  logic                 mem_oe,
    input  logic                 mem_we,
    input  logic                 mem_addr_valid,
    output logic                 mem_wait,
    output logic [31:0]          wr_word_count,
    output logic [31:0]          rd_word_count,
    output logic                 addr_error,
    output logic                 protocol_error
);

    // Remaining READ_WAIT edges before the edge that enters READ_BURST.
    localparam logic [3:0] WaitInit = 4'(READ_LATENCY - 2);

    state_e                    state_q, state_d;
    logic [MEM_DEPTH_LOG2-1:0] burst_addr_q, burst_addr_d;
    logic [3:0]                wait_cnt_q, wait_cnt_d;
    logic                      out_valid_q, out_valid_d;
    logic [31:0]               wr_cnt_q, wr_cnt_d;
    logic [31:0]               rd_cnt_q, rd_cnt_d;
    logic                      addr_err_q, addr_err_d;
    logic                      proto_err_q, proto_err_d;

    logic                      ram_we;
    logic [MEM_DEPTH_LOG2-1:0] ram_addr;
    logic [DataWidth-1:0]      ram_rdata;
    logic [MEM_DEPTH_LOG2-1:0] addr_lo;
    logic                      addr_hi_set;
    logic                      drive;

    assign addr_lo     = mem_addr[MEM_DEPTH_LOG2-1:0];
    assign addr_hi_set = |(mem_addr >> MEM_DEPTH_LOG2);

    always_comb begin
        state_d      = state_q;
        burst_addr_d = burst_addr_q;
        wait_cnt_d   = wait_cnt_q;
        out_valid_d  = out_valid_q;
        wr_cnt_d     = wr_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        addr_err_d   = addr_err_q;
        proto_err_d  = proto_err_q;
        ram_we       = 1'b0;
        ram_addr     = burst_addr_q;

        if (mem_addr_valid) begin
            ram_addr     = addr_lo;
            burst_addr_d = addr_lo;
            out_valid_d  = 1'b0;
            if (addr_hi_set) begin
                addr_err_d = 1'b1;
            end
            if (mem_we) begin
                ram_we       = 1'b1;
                burst_addr_d = addr_lo + MEM_DEPTH_LOG2'(1);
                wr_cnt_d     = wr_cnt_q + 32'd1;
                state_d      = StWriteBurst;
                if (mem_oe) begin
                    proto_err_d = 1'b1;
                end
            end else begin
                wait_cnt_d = WaitInit;
                state_d    = StReadWait;
            end
        end else begin
            unique case (state_q)
                StWriteBurst: begin
                    if (mem_we) begin
                        ram_we       = 1'b1;
                        burst_addr_d = burst_addr_q + MEM_DEPTH_LOG2'(1);
                        wr_cnt_d     = wr_cnt_q + 32'd1;
                    end else begin
                        state_d = StIdle;
                    end
                end
                StReadWait: begin
                    if (wait_cnt_q == 4'd0) begin
                        state_d = StReadBurst;
                    end else begin
                        wait_cnt_d = wait_cnt_q - 4'd1;
                    end
                end
                StReadBurst: begin
                    // The array registers the word at burst_addr on this edge.
                    if (mem_oe) begin
                        burst_addr_d = burst_addr_q + MEM_DEPTH_LOG2'(1);
                        rd_cnt_d     = rd_cnt_q + 32'd1;
                        out_valid_d  = 1'b1;
                    end else begin
                        out_valid_d = 1'b0;
                        state_d     = StIdle;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            burst_addr_q <= '0;
            wait_cnt_q   <= '0;
            out_valid_q  <= 1'b0;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            addr_err_q   <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            burst_addr_q <= burst_addr_d;
            wait_cnt_q   <= wait_cnt_d;
            out_valid_q  <= out_valid_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            addr_err_q   <= addr_err_d;
            proto_err_q  <= proto_err_d;
        end
    end

    // Writes are blocked while reset is held so an aborted burst leaves storage intact.
    cellram_array #(
        .MEM_DEPTH_LOG2(MEM_DEPTH_LOG2)
    ) u_array (
        .clk  (clk),
        .we   (ram_we & ~reset),
        .addr (ram_addr),
        .wdata(mem_data),
        .rdata(ram_rdata)
    );

    assign drive          = (state_q == StReadBurst) && mem_oe && out_valid_q;
    assign mem_data       = drive ? ram_rdata : {DataWidth{1'bz}};
    assign mem_wait       = (state_q == StReadWait);
    assign wr_word_count  = wr_cnt_q;
    assign rd_word_count  = rd_cnt_q;
    assign addr_error     = addr_err_q;
    assign protocol_error = proto_err_q;

endmodule

// File: tb/tb_cellram_responder.sv
// Self-checking bench for cellram_responder: directed bursts, a per-cycle
// edge-counting reference model, and literal expectations for key words.
module tb_cellram_responder;

    localparam int unsigned LOG2 = 16;
    localparam int unsigned LAT  = 3;

    logic        clk;
    logic        reset;
    logic [22:0] mem_addr;
    tri0  [15:0] mem_data;
    logic        mem_oe;
    logic        mem_we;
    logic        mem_addr_valid;
    logic        mem_wait;
    logic [31:0] wr_word_count;
    logic [31:0] rd_word_count;
    logic        addr_error;
    logic        protocol_error;

    logic        tb_drive;
    logic [15:0] tb_data;

    assign mem_data = tb_drive ? tb_data : 16'hzzzz;

    cellram_responder #(
        .MEM_DEPTH_LOG2(LOG2),
        .READ_LATENCY  (LAT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .mem_oe        (mem_oe),
        .mem_we        (mem_we),
        .mem_addr_valid(mem_addr_valid),
        .mem_wait      (mem_wait),
        .wr_word_count (wr_word_count),
        .rd_word_count (rd_word_count),
        .addr_error    (addr_error),
        .protocol_error(protocol_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 writing, 2 reading; m_n counts edges
    // since the read's address edge.
    logic [15:0] m_mem [2**LOG2];
    int          m_phase;
    int          m_n;
    logic [15:0] m_ptr;
    logic [15:0] m_word;
    logic [31:0] m_wr;
    logic [31:0] m_rd;
    logic        m_aerr;
    logic        m_perr;

    task automatic model_reset();
        m_phase = 0;
        m_n     = 0;
        m_wr    = 0;
        m_rd    = 0;
        m_aerr  = 1'b0;
        m_perr  = 1'b0;
    endtask

    task automatic model_edge();
        if (mem_addr_valid) begin
            if (mem_addr[22:16] != 7'd0) m_aerr = 1'b1;
            m_ptr = mem_addr[15:0];
            if (mem_we) begin
                if (mem_oe) m_perr = 1'b1;
                m_mem[m_ptr] = tb_data;
                m_ptr++;
                m_wr++;
                m_phase = 1;
            end else begin
                m_phase = 2;
                m_n     = 0;
            end
        end else if (m_phase == 1) begin
            if (mem_we) begin
                m_mem[m_ptr] = tb_data;
                m_ptr++;
                m_wr++;
            end else begin
                m_phase = 0;
            end
        end else if (m_phase == 2) begin
            m_n++;
            if (m_n >= LAT) begin
                if (mem_oe) begin
                    m_word = m_mem[m_ptr];
                    m_ptr++;
                    m_rd++;
                end else begin
                    m_phase = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic        exp_wait;
        logic        exp_drv;
        logic [15:0] exp_bus;
        exp_wait = (m_phase == 2) && (m_n < LAT - 1);
        exp_drv  = (m_phase == 2) && (m_n >= LAT) && mem_oe;
        exp_bus  = exp_drv ? m_word : (tb_drive ? tb_data : 16'h0000);
        chk("model mem_wait", 32'(mem_wait), 32'(exp_wait));
        chk("model mem_data", 32'(mem_data), 32'(exp_bus));
        chk("model wr_count", wr_word_count, m_wr);
        chk("model rd_count", rd_word_count, m_rd);
        chk("model addr_error", 32'(addr_error), 32'(m_aerr));
        chk("model protocol_error", 32'(protocol_error), 32'(m_perr));
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else model_edge();
            #1;
            compare_all();
        end
    end

    task automatic step(input logic v, input logic we, input logic oe, input logic [22:0] a,
                        input logic drv, input logic [15:0] d);
        @(negedge clk);
        mem_addr_valid = v;
        mem_we         = we;
        mem_oe         = oe;
        mem_addr       = a;
        tb_drive       = drv;
        tb_data        = d;
        @(posedge clk);
        #2;
    endtask

    task automatic wr_addr(input logic [22:0] a, input logic [15:0] d);
        step(1'b1, 1'b1, 1'b0, a, 1'b1, d);
    endtask
    task automatic wr_next(input logic [15:0] d);
        step(1'b0, 1'b1, 1'b0, 23'd0, 1'b1, d);
    endtask
    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 23'd0, 1'b0, 16'd0);
    endtask
    task automatic rd_addr(input logic [22:0] a);
        step(1'b1, 1'b0, 1'b1, a, 1'b0, 16'd0);
    endtask
    task automatic rd_next();
        step(1'b0, 1'b0, 1'b1, 23'd0, 1'b0, 16'd0);
    endtask

    initial begin
        n_cmp          = 0;
        n_bad          = 0;
        reset          = 1'b1;
        mem_addr_valid = 1'b0;
        mem_we         = 1'b0;
        mem_oe         = 1'b0;
        mem_addr       = '0;
        tb_drive       = 1'b0;
        tb_data        = '0;
        #1;
        chk("reset mem_wait", 32'(mem_wait), 32'd0);
        chk("reset mem_data", 32'(mem_data), 32'd0);
        chk("reset wr_count", wr_word_count, 32'd0);
        chk("reset addr_error", 32'(addr_error), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Four-word write burst then read-back with latency 3.
        wr_addr(23'h000010, 16'hA000);
        wr_next(16'hA001);
        wr_next(16'hA002);
        wr_next(16'hA003);
        idle();
        rd_addr(23'h000010);
        chk("rd1 wait e0", 32'(mem_wait), 32'd1);
        rd_next();
        chk("rd1 wait e1", 32'(mem_wait), 32'd1);
        rd_next();
        chk("rd1 wait e2", 32'(mem_wait), 32'd0);
        rd_next();
        chk("rd1 word0", 32'(mem_data), 32'h0000A000);
        rd_next();
        chk("rd1 word1", 32'(mem_data), 32'h0000A001);
        rd_next();
        chk("rd1 word2", 32'(mem_data), 32'h0000A002);
        rd_next();
        chk("rd1 word3", 32'(mem_data), 32'h0000A003);
        idle();
        chk("rd1 wr_count", wr_word_count, 32'd4);
        chk("rd1 rd_count", rd_word_count, 32'd4);

        // Burst address wrap at the top of the array.
        wr_addr(23'h00FFFF, 16'hBEEF);
        wr_next(16'h1234);
        idle();
        rd_addr(23'h00FFFF);
        rd_next();
        rd_next();
        rd_next();
        chk("wrap word0", 32'(mem_data), 32'h0000BEEF);
        rd_next();
        chk("wrap word1", 32'(mem_data), 32'h00001234);
        idle();

        // High address bits alias onto the array and raise addr_error.
        chk("alias pre addr_error", 32'(addr_error), 32'd0);
        wr_addr(23'h410000, 16'h5555);
        idle();
        chk("alias addr_error", 32'(addr_error), 32'd1);
        rd_addr(23'h000000);
        rd_next();
        rd_next();
        rd_next();
        chk("alias word", 32'(mem_data), 32'h00005555);
        idle();

        // we and oe together on an address edge: write wins.
        chk("proto pre", 32'(protocol_error), 32'd0);
        step(1'b1, 1'b1, 1'b1, 23'h000040, 1'b1, 16'h7777);
        chk("proto bus", 32'(mem_data), 32'h00007777);
        idle();
        chk("proto error", 32'(protocol_error), 32'd1);
        chk("proto bus idle", 32'(mem_data), 32'd0);
        rd_addr(23'h000040);
        rd_next();
        rd_next();
        rd_next();
        chk("proto word", 32'(mem_data), 32'h00007777);
        idle();

        // New address edge during READ_WAIT restarts the latency.
        wr_addr(23'h000020, 16'h2020);
        wr_addr(23'h000030, 16'h3030);
        idle();
        rd_addr(23'h000020);
        rd_next();
        rd_addr(23'h000030);
        chk("restart wait e0", 32'(mem_wait), 32'd1);
        rd_next();
        chk("restart wait e1", 32'(mem_wait), 32'd1);
        rd_next();
        chk("restart wait e2", 32'(mem_wait), 32'd0);
        rd_next();
        chk("restart word0", 32'(mem_data), 32'h00003030);
        idle();

        // Asynchronous reset in the middle of a read burst.
        rd_addr(23'h000010);
        rd_next();
        rd_next();
        rd_next();
        rd_next();
        chk("mid burst word1", 32'(mem_data), 32'h0000A001);
        reset = 1'b1;
        #1;
        chk("async rst mem_wait", 32'(mem_wait), 32'd0);
        chk("async rst mem_data", 32'(mem_data), 32'd0);
        chk("async rst wr_count", wr_word_count, 32'd0);
        chk("async rst rd_count", rd_word_count, 32'd0);
        chk("async rst addr_error", 32'(addr_error), 32'd0);
        chk("async rst protocol_error", 32'(protocol_error), 32'd0);
        repeat (2) @(posedge clk);
        // First edge after release is an address edge.
        @(negedge clk);
        reset          = 1'b0;
        mem_addr_valid = 1'b1;
        mem_we         = 1'b0;
        mem_oe         = 1'b1;
        mem_addr       = 23'h000011;
        @(posedge clk);
        #2;
        chk("post rst wait", 32'(mem_wait), 32'd1);
        rd_next();
        rd_next();
        rd_next();
        chk("post rst word", 32'(mem_data), 32'h0000A001);
        rd_next();
        chk("post rst word2", 32'(mem_data), 32'h0000A002);
        idle();
        chk("post rst rd_count", rd_word_count, 32'd2);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cellram_responder.md
CELLRAM_RESPONDER -- requirements
Module: cellram_responder

Interface
REQ-001 SHALL have parameter MEM_DEPTH_LOG2, default 16: log2 of stored 16-bit words.
REQ-002 SHALL have parameter READ_LATENCY, default 3: edges from address sample to first read word; legal range 2..15.
REQ-003 SHALL have port clk, input, 1: single clock, identical to the arbitrator's mem_clk; all sampling on rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high.
REQ-005 SHALL have port mem_addr, input, 23: word address, sampled only when mem_addr_valid=1.
REQ-006 SHALL have port mem_data, inout, 16: write data in, read data out.
REQ-007 SHALL have port mem_oe, input, 1: active-high read enable/advance.
REQ-008 SHALL have port mem_we, input, 1: active-high write enable/advance.
REQ-009 SHALL have port mem_addr_valid, input, 1: active-high address strobe, starts a burst.
REQ-010 SHALL have port mem_wait, output, 1: high while read data not yet valid.
REQ-011 SHALL have ports wr_word_count and rd_word_count, output, 32 each: words written/read, wrapping modulo 2^32.
REQ-012 SHALL have port addr_error, output, 1: sticky; an address had nonzero bits above MEM_DEPTH_LOG2.
REQ-013 SHALL have port protocol_error, output, 1: sticky; mem_we and mem_oe were both high on an address edge.

Function
REQ-014 SHALL implement states IDLE, WRITE_BURST, READ_WAIT, READ_BURST, with an internal burst address of MEM_DEPTH_LOG2 bits.
REQ-015 At any edge with mem_addr_valid=1, in any state, SHALL latch mem_addr[MEM_DEPTH_LOG2-1:0] as burst address and restart; mem_addr_valid takes precedence over burst continuation.
REQ-016 Address edge with mem_we=1: SHALL write mem_data to the latched address, set burst address +1, enter WRITE_BURST; write wins if mem_oe=1 as well, and protocol_error sets.
REQ-017 WRITE_BURST: each edge with mem_we=1 SHALL write mem_data at burst address and increment; mem_we=0 SHALL return to IDLE with no write.
REQ-018 Address edge with mem_we=0, mem_oe=1 or 0: SHALL enter READ_WAIT and assert mem_wait from that edge.
REQ-019 READ_WAIT SHALL last READ_LATENCY-1 edges, then enter READ_BURST and deassert mem_wait; the word at the latched address SHALL be stable on mem_data between edge READ_LATENCY and edge READ_LATENCY+1 after the address edge.
REQ-020 READ_BURST: each edge with mem_oe=1 SHALL advance burst address so the next word appears after that edge; mem_oe=0 at an edge SHALL return to IDLE.
REQ-021 mem_data SHALL be driven only in READ_BURST while mem_oe=1; otherwise high-impedance.
REQ-022 Burst address SHALL wrap from 2^MEM_DEPTH_LOG2-1 to 0 without error.
REQ-023 Address bits above MEM_DEPTH_LOG2 SHALL be ignored for access (aliasing) and SHALL set addr_error.
REQ-024 wr_word_count SHALL increment once per word written; rd_word_count once per read word consumed (READ_BURST edge with mem_oe=1).
REQ-025 Read-after-write to the same address with no intervening address edge SHALL return the new data.

Reset
REQ-026 reset SHALL force IDLE, mem_wait=0, mem_data high-impedance, counters=0, addr_error=0, protocol_error=0, asynchronously.
REQ-027 reset mid-burst SHALL abort without further writes; array contents SHALL NOT be cleared.
REQ-028 First edge after reset release SHALL be a legal address edge.

Structure
REQ-029 State encodings and default READ_LATENCY SHALL live in the shared cellram package.
REQ-030 Storage SHALL be sub-module cellram_array: single-port, synchronous write, one-cycle synchronous read, 2^MEM_DEPTH_LOG2 x 16; the latency pipeline lives in cellram_responder.

Verification
REQ-031 Write burst 0x0010..0x0013 with data 0xA000..0xA003, then read burst at 0x0010 -> mem_wait high 2 edges, data 0xA000..0xA003 on edges 3..6; wr/rd counts 4/4.
REQ-032 Write 0xBEEF at address 0xFFFF, continue burst 0x1234 -> 0x1234 stored at 0x0000; read burst from 0xFFFF returns 0xBEEF, 0x1234.
REQ-033 Address 0x410000 write 0x5555 -> addr_error=1, read of 0x0000 returns 0x5555.
REQ-034 Address edge with mem_we=1 and mem_oe=1, data 0x7777 -> write performed, protocol_error=1, mem_data never driven.
REQ-035 reset asserted during READ_BURST mid-cycle -> mem_data Z and mem_wait 0 immediately; counts 0; earlier-written data still readable.
REQ-036 Read burst at 0x0020, new address edge at 0x0030 during READ_WAIT -> latency restarts, first word from 0x0030.
